// File: rtl/subkey_schedule_pkg.sv
// Shared definitions for the subkey schedule generator.
//   NUM_ROUNDS / KEY_W / HALF_W / ROUND_W : fixed geometry of the schedule
//   SHIFT1_MASK / shift_amount()         : per-round rotate amount s(i)
//   state_t                              : FSM state encoding
package subkey_schedule_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int KEY_W      = 64;
    localparam int HALF_W     = KEY_W / 2;
    localparam int ROUND_W    = 4;

    // Bit i set means round i rotates by 1; every other round rotates by 2.
    // Rounds 0, 1, 8 and 15 are the single-step rounds.
    localparam logic [NUM_ROUNDS-1:0] SHIFT1_MASK = 16'b1000_0001_0000_0011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [1:0] shift_amount(input logic [ROUND_W-1:0] round);
        return SHIFT1_MASK[round] ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/subkey_round.sv
// One round of the subkey schedule, purely combinational.
//   c, d     : current 32-bit halves
//   round    : round index 0..15
//   c_next   : c rotated left by s(round)
//   d_next   : d rotated left by s(round)
//   subkey   : {c_next, d_next} XOR the round index replicated in every nibble
module subkey_round
    import subkey_schedule_pkg::*;
(
    input  logic [HALF_W-1:0]  c,
    input  logic [HALF_W-1:0]  d,
    input  logic [ROUND_W-1:0] round,
    output logic [HALF_W-1:0]  c_next,
    output logic [HALF_W-1:0]  d_next,
    output logic [KEY_W-1:0]   subkey
);

    logic             rot_two;
    logic [KEY_W-1:0] tweak;

    assign rot_two = (shift_amount(round) == 2'd2);

    // Only two rotate amounts exist, so a 2:1 mux of fixed rotations is all
    // that is needed; the two halves never exchange bits.
    assign c_next = rot_two ? {c[HALF_W-3:0], c[HALF_W-1:HALF_W-2]}
                            : {c[HALF_W-2:0], c[HALF_W-1]};
    assign d_next = rot_two ? {d[HALF_W-3:0], d[HALF_W-1:HALF_W-2]}
                            : {d[HALF_W-2:0], d[HALF_W-1]};

    genvar gi;
    generate
        for (gi = 0; gi < KEY_W / ROUND_W; gi++) begin : g_tweak
            assign tweak[gi*ROUND_W +: ROUND_W] = round;
        end
    endgenerate

    assign subkey = {c_next, d_next} ^ tweak;

endmodule

// File: rtl/subkey_schedule.sv
// Generates 16 round subkeys from a 64-bit master key and streams them into
// an external RAM, one write per cycle at addresses 0..15.
//   ap_clk, ap_rst           : clock, asynchronous active-high reset
//   ap_start                 : begin a schedule (honoured only in IDLE)
//   ap_done, ap_ready        : one-cycle pulse after the last write
//   ap_idle                  : high while in IDLE
//   key                      : master key, captured on the accepting edge
//   sub_key_address0/ce0/we0/d0 : RAM write port
module subkey_schedule
    import subkey_schedule_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    input  logic [KEY_W-1:0]   key,
    output logic [ROUND_W-1:0] sub_key_address0,
    output logic               sub_key_ce0,
    output logic               sub_key_we0,
    output logic [KEY_W-1:0]   sub_key_d0
);

    state_t              state_reg;
    logic [HALF_W-1:0]   c_reg;
    logic [HALF_W-1:0]   d_reg;
    logic [ROUND_W-1:0]  round_reg;
    logic                done_reg;
    logic                idle_reg;

    logic [HALF_W-1:0]   c_next;
    logic [HALF_W-1:0]   d_next;
    logic [KEY_W-1:0]    subkey;
    logic                write_active;

    subkey_round u_round (
        .c      (c_reg),
        .d      (d_reg),
        .round  (round_reg),
        .c_next (c_next),
        .d_next (d_next),
        .subkey (subkey)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_reg <= ST_IDLE;
            c_reg     <= '0;
            d_reg     <= '0;
            round_reg <= '0;
            done_reg  <= 1'b0;
            idle_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (ap_start) begin
                        c_reg     <= key[KEY_W-1:HALF_W];
                        d_reg     <= key[HALF_W-1:0];
                        round_reg <= '0;
                        idle_reg  <= 1'b0;
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    c_reg     <= c_next;
                    d_reg     <= d_next;
                    // The 15->0 wrap lands exactly on the exit to DONE, so the
                    // counter never produces a 17th address.
                    round_reg <= round_reg + 4'd1;
                    if (round_reg == ROUND_W'(NUM_ROUNDS - 1)) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    idle_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    idle_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // The write port is a decode of the state register, so reset removes it
    // immediately without waiting for a clock edge.
    assign write_active     = (state_reg == ST_WRITE);
    assign sub_key_ce0      = write_active;
    assign sub_key_we0      = write_active;
    assign sub_key_address0 = write_active ? round_reg : '0;
    assign sub_key_d0       = write_active ? subkey : '0;

    assign ap_done  = done_reg;
    assign ap_ready = done_reg;
    assign ap_idle  = idle_reg;

endmodule

// File: tb/tb_subkey_schedule.sv
// Randomized self-checking bench for subkey_schedule. A behavioural model
// computes the 16 expected subkeys from the key with plain shifts and
// arithmetic; every output is compared cycle by cycle on the falling edge.
module tb_subkey_schedule;

    logic        ap_clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [63:0] key;
    logic [3:0]  sub_key_address0;
    logic        sub_key_ce0;
    logic        sub_key_we0;
    logic [63:0] sub_key_d0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_keys [16];
    logic [63:0] captured [16];

    subkey_schedule dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .key              (key),
        .sub_key_address0 (sub_key_address0),
        .sub_key_ce0      (sub_key_ce0),
        .sub_key_we0      (sub_key_we0),
        .sub_key_d0       (sub_key_d0)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference schedule: rotate each half left by s(r), then XOR r into
    // every nibble (r * 0x1111... places r in all 16 nibbles).
    task automatic compute_model(input logic [63:0] k);
        logic [31:0] c;
        logic [31:0] d;
        int s;
        c = k[63:32];
        d = k[31:0];
        for (int r = 0; r < 16; r++) begin
            s = (r == 0 || r == 1 || r == 8 || r == 15) ? 1 : 2;
            c = (c << s) | (c >> (32 - s));
            d = (d << s) | (d >> (32 - s));
            exp_keys[r] = {c, d} ^ (64'h1111_1111_1111_1111 * 64'(r));
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ce0"},  64'(sub_key_ce0), 64'd0);
        check_eq({tag, "_we0"},  64'(sub_key_we0), 64'd0);
        check_eq({tag, "_addr"}, 64'(sub_key_address0), 64'd0);
        check_eq({tag, "_d0"},   sub_key_d0, 64'd0);
        check_eq({tag, "_done"}, 64'(ap_done), 64'd0);
        check_eq({tag, "_ready"}, 64'(ap_ready), 64'd0);
    endtask

    // Entry: at a falling edge with key=k_used and ap_start=1 already driven,
    // so the next rising edge is the accepting edge 0. Checks cycles 1..18
    // and returns at the falling edge inside cycle 18. With hold=1 ap_start
    // stays high, so the next rising edge accepts again (with k_after).
    task automatic run_check(input logic [63:0] k_used, input bit hold, input logic [63:0] k_after);
        int idle_low;
        int done_cnt;
        idle_low = 0;
        done_cnt = 0;
        compute_model(k_used);
        @(posedge ap_clk);
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge ap_clk);
            if (ap_idle === 1'b0) idle_low++;
            if (ap_done === 1'b1) done_cnt++;
            check_eq("ready_eq_done", 64'(ap_ready), 64'(ap_done));
            if (cyc <= 16) begin
                check_eq("wr_ce0",  64'(sub_key_ce0), 64'd1);
                check_eq("wr_we0",  64'(sub_key_we0), 64'd1);
                check_eq("wr_addr", 64'(sub_key_address0), 64'(cyc - 1));
                check_eq("wr_d0",   sub_key_d0, exp_keys[cyc-1]);
                check_eq("wr_idle", 64'(ap_idle), 64'd0);
                check_eq("wr_done", 64'(ap_done), 64'd0);
                captured[cyc-1] = sub_key_d0;
            end else if (cyc == 17) begin
                check_eq("dn_done", 64'(ap_done), 64'd1);
                check_eq("dn_idle", 64'(ap_idle), 64'd0);
                check_eq("dn_ce0",  64'(sub_key_ce0), 64'd0);
                check_eq("dn_addr", 64'(sub_key_address0), 64'd0);
                check_eq("dn_d0",   sub_key_d0, 64'd0);
            end else begin
                check_eq("end_idle", 64'(ap_idle), 64'd1);
                check_quiet("end");
            end
            // Drive for the following edge: key change after acceptance must
            // be ignored; stray start pulses in WRITE/DONE must be ignored.
            if (cyc == 5) key = k_after;
            if (!hold) begin
                if (cyc >= 2 && cyc <= 16) ap_start = 1'($urandom_range(0, 1));
                else ap_start = 1'b0;
            end
        end
        check_eq("idle_low_cycles", 64'(idle_low), 64'd17);
        check_eq("done_pulses", 64'(done_cnt), 64'd1);
        $display("run key=0x%016h hold=%0d subkey15=0x%016h", k_used, hold, captured[15]);
    endtask

    task automatic idle_gap(input int n);
        for (int g = 0; g < n; g++) begin
            @(negedge ap_clk);
            check_eq("gap_idle", 64'(ap_idle), 64'd1);
            check_quiet("gap");
        end
    endtask

    initial begin
        logic [63:0] k1;
        logic [63:0] k2;
        logic [63:0] kr;
        int done_seen;

        ap_rst   = 1'b0;
        ap_start = 1'b0;
        key      = '0;
        #1 ap_rst = 1'b1;
        #2;
        check_eq("rst_idle", 64'(ap_idle), 64'd1);
        check_quiet("rst");
        ap_start = 1'b1;             // ignored while reset is held
        repeat (2) @(negedge ap_clk);
        check_eq("rst_hold_ce0", 64'(sub_key_ce0), 64'd0);
        ap_start = 1'b0;
        ap_rst   = 1'b0;
        idle_gap(2);

        // All-zero key: data is just the round index in every nibble.
        key = 64'd0;
        ap_start = 1'b1;
        run_check(64'd0, 1'b0, {$urandom, $urandom});
        check_eq("k0_addr5",  captured[5],  64'h5555_5555_5555_5555);
        check_eq("k0_addr15", captured[15], 64'hFFFF_FFFF_FFFF_FFFF);
        $display("directed key=0 addr5=0x%016h addr15=0x%016h", captured[5], captured[15]);

        key = 64'h0000_0001_0000_0001;
        ap_start = 1'b1;
        run_check(64'h0000_0001_0000_0001, 1'b0, {$urandom, $urandom});
        check_eq("k1_addr0", captured[0], 64'h0000_0002_0000_0002);
        check_eq("k1_addr1", captured[1], 64'h1111_1115_1111_1115);
        check_eq("k1_addr2", captured[2], 64'h2222_2232_2222_2232);
        $display("directed key=1_1 addr0..2=0x%016h 0x%016h 0x%016h", captured[0], captured[1], captured[2]);

        // Start held across two runs; key swapped mid-run. Second run's
        // write 0 must appear right after cycle 18 using the new key.
        k1 = {$urandom, $urandom};
        k2 = {$urandom, $urandom};
        key = k1;
        ap_start = 1'b1;
        run_check(k1, 1'b1, k2);
        run_check(k2, 1'b0, {$urandom, $urandom});

        for (int n = 0; n < 6; n++) begin
            idle_gap(int'($urandom_range(0, 3)));
            kr = {$urandom, $urandom};
            @(negedge ap_clk);
            key = kr;
            ap_start = 1'b1;
            run_check(kr, 1'b0, {$urandom, $urandom});
        end

        // Reset in the middle of the write to address 7.
        kr = {$urandom, $urandom};
        compute_model(kr);
        @(negedge ap_clk);
        key = kr;
        ap_start = 1'b1;
        @(posedge ap_clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
        end
        check_eq("abort_pre_addr", 64'(sub_key_address0), 64'd7);
        check_eq("abort_pre_ce0",  64'(sub_key_ce0), 64'd1);
        check_eq("abort_pre_d0",   sub_key_d0, exp_keys[7]);
        #1 ap_rst = 1'b1;
        #1;
        check_eq("abort_ce0",  64'(sub_key_ce0), 64'd0);
        check_eq("abort_we0",  64'(sub_key_we0), 64'd0);
        check_eq("abort_idle", 64'(ap_idle), 64'd1);
        done_seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge ap_clk);
            if (cyc == 3) ap_rst = 1'b0;
            if (ap_done === 1'b1) done_seen++;
            check_eq("abort_quiet_ce0", 64'(sub_key_ce0), 64'd0);
            check_eq("abort_quiet_idle", 64'(ap_idle), 64'd1);
        end
        check_eq("abort_no_done", 64'(done_seen), 64'd0);
        $display("reset abort at addr 7 key=0x%016h done_pulses=%0d", kr, done_seen);

        // Recovery run after the abort.
        kr = {$urandom, $urandom};
        key = kr;
        ap_start = 1'b1;
        run_check(kr, 1'b0, {$urandom, $urandom});
        idle_gap(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/subkey_schedule.md
SUBKEY_SCHEDULE -- requirements
Module: subkey_schedule

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (64-bit key, 16 subkeys, 4-bit address).
REQ-002 ap_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 ap_rst  input  1  reset, asynchronous and active-high.
REQ-004 ap_start  input  1  request to generate a schedule; sampled only in IDLE.
REQ-005 ap_done  output  1  one-cycle pulse when all 16 subkeys are written.
REQ-006 ap_idle  output  1  high exactly while in IDLE.
REQ-007 ap_ready  output  1  one-cycle pulse, coincident with ap_done.
REQ-008 key  input  64  master key; sampled on the accepting edge only.
REQ-009 sub_key_address0  output  4  RAM write address, round index 0..15.
REQ-010 sub_key_ce0  output  1  RAM chip enable.
REQ-011 sub_key_we0  output  1  RAM write enable; equals sub_key_ce0.
REQ-012 sub_key_d0  output  64  subkey write data.

Function
REQ-013 FSM states SHALL be IDLE, WRITE, DONE.
- IDLE->WRITE when ap_start=1.
- WRITE->DONE after round 15.
- DONE->IDLE unconditionally.
REQ-014 On the accepting edge, the block SHALL latch C=key[63:32], D=key[31:0] and clear round counter i to 0.
REQ-015 Shift amount s(i) SHALL be 1 for i in {0,1,8,15} and 2 otherwise.
REQ-016 In WRITE round i, the block SHALL drive both of the following combinationally from the registered C and D:
- C' = C rotl s(i), D' = D rotl s(i) (each 32-bit rotation independent);
- sub_key_d0 = {C',D'} XOR {16{i[3:0]}}, sub_key_address0=i, ce0=we0=1.
REQ-017 At the end of each WRITE cycle, the block SHALL register C<=C', D<=D' and i<=i+1.
REQ-018 Exactly 16 writes SHALL occur, one per cycle, at consecutive addresses 0..15 with no gaps.
REQ-019 Latency SHALL be:
- accept at edge 0;
- writes on cycles 1..16;
- ap_done=ap_ready=1 on cycle 17 only;
- ap_idle=1 again from cycle 18.
REQ-020 Outside WRITE, the block SHALL hold ce0=we0=0; address0 and d0 are don't-care but SHALL be driven to 0.
REQ-021 The block SHALL ignore ap_start in WRITE and DONE; key changes after acceptance SHALL have no effect.
REQ-022 If ap_start is held high continuously, a new schedule SHALL be accepted on the edge ending the first IDLE cycle after DONE (one idle cycle between runs).
REQ-023 The 4-bit counter SHALL NOT wrap into a 17th write; the 15->0 wrap coincides with the WRITE->DONE transition.

Reset
REQ-024 While ap_rst=1, the block SHALL immediately hold the state below, regardless of clock:
- state=IDLE, C=D=0, i=0;
- ap_done=ap_ready=0, ap_idle=1;
- ce0=we0=0, address0=0, d0=0.
REQ-025 Reset asserted mid-WRITE SHALL abort the run with no further writes; the RAM contents written so far are left as-is.
REQ-026 After reset deasserts, the first acceptance SHALL occur no earlier than the first rising edge with ap_start=1.

Structure
REQ-027 A shared package SHALL hold:
- NUM_ROUNDS=16, KEY_W=64;
- the s(i) shift table;
- the FSM state enum.
REQ-028 Rotation and XOR SHALL live in one combinational sub-module, subkey_round (inputs C, D, i; outputs C', D', subkey); the FSM and registers stay in the top level.

Verification
REQ-029 key=0, start pulse: SHALL produce exactly 16 writes with d0={16{i}}; addr 5 -> 0x5555555555555555, addr 15 -> 0xFFFFFFFFFFFFFFFF; ap_done at cycle 17.
REQ-030 key=0x0000000100000001: SHALL produce addr0 -> 0x0000000200000002, addr1 -> 0x1111111511111115, addr2 -> 0x2222223222222232.
REQ-031 Hold ap_start=1 across two runs with key changed mid-run: first run SHALL use its original key; second acceptance SHALL occur at cycle 18 with the new key.
REQ-032 Assert ap_rst asynchronously during the write to address 7: ce0/we0 SHALL drop before the next edge, ap_idle=1, and ap_done SHALL never pulse.
REQ-033 Bench SHALL check ap_done and ap_ready are single-cycle, coincident, and that ap_idle=0 for exactly 17 cycles per run.
